// File: rtl/fifo_pkg.sv
// Shared defaults and pointer helper for the flop-based FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_DEPTH_DFLT = 16;
    localparam int unsigned FIFO_BITS_DFLT  = 16;

    // Wrapping increment that also works when depth is not a power of two.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_flops_ctrl.sv
// Pointer, occupancy and accept logic for the flop FIFO; storage lives in the top.
module fifo_flops_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned depth = FIFO_DEPTH_DFLT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    output logic                       wr_en,
    output logic [$clog2(depth)-1:0]   wr_ptr,
    output logic [$clog2(depth)-1:0]   rd_ptr,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       full,
    output logic                       pndng
);

    localparam int unsigned PtrW = $clog2(depth);
    localparam int unsigned CntW = $clog2(depth + 1);

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push_ok, pop_ok;

    always_comb begin
        full    = (count_q == CntW'(depth));
        pndng   = (count_q != '0);
        // A pop in the same cycle frees the slot that a push into a full FIFO needs.
        push_ok = push & (~full | pop);
        pop_ok  = pop & pndng;
        wr_en   = push_ok;
        wr_ptr  = wr_ptr_q;
        rd_ptr  = rd_ptr_q;
        count   = count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= PtrW'(ptr_inc(32'(wr_ptr_q), depth));
            end
            if (pop_ok) begin
                rd_ptr_q <= PtrW'(ptr_inc(32'(rd_ptr_q), depth));
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fifo_flops.sv
// Show-ahead single-clock FIFO with flip-flop storage; head word is always on Dout.
module fifo_flops
    import fifo_pkg::*;
#(
    parameter int unsigned depth = FIFO_DEPTH_DFLT,
    parameter int unsigned bits  = FIFO_BITS_DFLT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] Din,
    input  logic            push,
    input  logic            pop,
    output logic [bits-1:0] Dout,
    output logic            full,
    output logic            pndng
);

    logic [$clog2(depth)-1:0]   wr_ptr, rd_ptr;
    logic [$clog2(depth+1)-1:0] count;
    logic                       wr_en;
    logic [bits-1:0]            mem [depth];

    fifo_flops_ctrl #(
        .depth (depth)
    ) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .wr_en  (wr_en),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .pndng  (pndng)
    );

    // Storage is cleared on reset so Dout reads 0 until the first write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(depth); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= Din;
        end
    end

    assign Dout = mem[rd_ptr];

endmodule

// File: tb/tb_fifo_flops.sv
// Directed bench for fifo_flops (depth 16, 16-bit words) with a small queue model.
module tb_fifo_flops;

    localparam int unsigned Depth = 16;
    localparam int unsigned Bits  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [Bits-1:0] din;
    logic            push, pop;
    logic [Bits-1:0] dout;
    logic            full, pndng;

    int n_tests = 0;
    int n_fail  = 0;
    int q[$];

    fifo_flops #(
        .depth (Depth),
        .bits  (Bits)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .Din   (din),
        .push  (push),
        .pop   (pop),
        .Dout  (dout),
        .full  (full),
        .pndng (pndng)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock with the given inputs; head is checked before the edge, state after.
    task automatic cycle(input logic p, input logic r, input int d);
        bit push_ok, pop_ok;
        push = p;
        pop  = r;
        din  = Bits'(d);
        if (q.size() != 0) check("dout_head", 32'(dout), 32'(q[0]));
        pop_ok  = r && (q.size() != 0);
        push_ok = p && ((q.size() != Depth) || r);
        @(posedge clk);
        #1;
        if (pop_ok)  void'(q.pop_front());
        if (push_ok) q.push_back(d);
        check("count", 32'(dut.count), 32'(q.size()));
        check("full",  32'(full),  32'(q.size() == Depth));
        check("pndng", 32'(pndng), 32'(q.size() != 0));
    endtask

    initial begin
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        din  = '0;

        // 1: reset
        repeat (5) @(posedge clk);
        #1;
        check("rst_count", 32'(dut.count), 0);
        check("rst_full",  32'(full),  0);
        check("rst_pndng", 32'(pndng), 0);
        check("rst_dout",  32'(dout),  0);
        rst = 1'b1;

        // 2: fill 0..15
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, i);
            if (i == 14) check("full_at_15", 32'(full), 0);
        end
        check("fill_count", 32'(dut.count), 16);
        check("fill_full",  32'(full),  1);
        check("fill_pndng", 32'(pndng), 1);
        check("fill_dout",  32'(dout),  0);

        // 3: overflow
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 99);
        check("ovf_count", 32'(dut.count), 16);

        // 4: drain with hand-computed order, then underflow
        for (int i = 0; i < 16; i++) begin
            check("drain_dout", 32'(dout), 32'(i));
            cycle(1'b0, 1'b1, 0);
        end
        check("drain_pndng", 32'(pndng), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 0);
        check("udf_count", 32'(dut.count), 0);
        check("udf_dout_hold", 32'(dout), 0);
        cycle(1'b1, 1'b0, 7);
        check("push7_dout", 32'(dout), 7);

        // 5: simultaneous push+pop at count 5, wrapping pointers
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 200 + i);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 100 + i);
        check("pp_count", 32'(dut.count), 5);
        check("pp_dout",  32'(dout), 115);
        while (q.size() < Depth) cycle(1'b1, 1'b0, 300 + q.size());
        cycle(1'b1, 1'b1, 500);
        check("pp_full_keep", 32'(full), 1);
        check("pp_full_dout", 32'(dout), 116);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 0);
        check("pp_empty", 32'(pndng), 0);

        // 6: push+pop on empty
        cycle(1'b1, 1'b1, 42);
        check("e_pp_count", 32'(dut.count), 1);
        check("e_pp_pndng", 32'(pndng), 1);
        check("e_pp_dout",  32'(dout), 42);

        // Mid-fill async reset takes effect without a clock edge
        for (int i = 1; i < 4; i++) cycle(1'b1, 1'b0, i);
        push = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("mid_rst_count", 32'(dut.count), 0);
        check("mid_rst_full",  32'(full),  0);
        check("mid_rst_pndng", 32'(pndng), 0);
        check("mid_rst_dout",  32'(dout),  0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        cycle(1'b1, 1'b0, 9);
        check("post_rst_dout", 32'(dout), 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
